// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter family.
//   dir_t        : count direction encoding (matches the 'up' input bit)
//   clog2_min1   : ceil(log2(n)) clamped to at least 1, used for counter width
//   MAX_MODULUS  : largest supported modulus
package counter_pkg;

  localparam int unsigned MAX_MODULUS = 65536;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Width needed to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int n);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(n)) w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter_bit_cell.sv
// One storage bit of the counter: async-clear D flop fed by either a
// parallel-load value or its own output XOR a toggle enable.
//   clk : rising-edge clock
//   clr : asynchronous active-high clear (forces q to RST)
//   t   : toggle enable (q ^ t when not loading)
//   ld  : load select, takes priority over t
//   d   : load value
//   q   : stored bit
module counter_bit_cell #(
  parameter logic RST = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)     q <= RST;
    else if (ld) q <= d;
    else         q <= q ^ t;
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Synchronous modulo-MODULUS up/down counter built from counter_bit_cell
// toggle flops. Cascadable: tc of one stage drives en of the next.
//   clk  : rising-edge clock
//   clr  : asynchronous active-high reset (q=RESET_VAL, wrap=0, err=0)
//   en   : count enable / cascade input
//   up   : 1 = increment, 0 = decrement
//   load : synchronous parallel load (priority over en)
//   d    : load value; values >= MODULUS load MODULUS-1 and set err
//   q    : current count
//   tc   : terminal count, combinational
//   wrap : registered pulse in the cycle q shows a wrapped value
//   err  : sticky illegal-load flag, cleared by clr or a legal load
// Build option: define COUNTER_UPDOWN_MOD_SAT_EN to saturate at the range
// ends instead of wrapping (wrap then stays 0).
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned MODULUS   = 10,
  parameter int unsigned RESET_VAL = 0,
  localparam int unsigned WIDTH    = clog2_min1(int'(MODULUS))
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  // Elaboration-time parameter legality.
  if (MODULUS < 2 || MODULUS > MAX_MODULUS) begin : g_bad_modulus
    $error("counter_updown_mod: MODULUS must be in 2..65536");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("counter_updown_mod: RESET_VAL must be < MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);

  dir_t             dir;
  logic             at_term_c;
  logic             legal_ld_c;
  logic [WIDTH-1:0] ld_val_c;
  logic [WIDTH-1:0] t_c;
  logic             ld_c;
  logic [WIDTH-1:0] d_c;
  logic             chain_c;
  logic             wrap_nxt_c;

  assign dir        = dir_t'(up);
  assign at_term_c  = (dir == DIR_UP) ? (q == MAX_Q) : (q == '0);
  assign tc         = en & at_term_c;
  // Extend by one bit so MODULUS=2**WIDTH compares correctly.
  assign legal_ld_c = ({1'b0, d} < MOD_EXT);
  assign ld_val_c   = legal_ld_c ? d : MAX_Q;

  // Per-bit toggle enables plus load / terminal override.
  always_comb begin
    t_c        = '0;
    ld_c       = 1'b0;
    d_c        = ld_val_c;
    wrap_nxt_c = 1'b0;
    // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
    chain_c    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_c[i]  = en & chain_c;
      chain_c = chain_c & ((dir == DIR_UP) ? q[i] : ~q[i]);
    end
    if (load) begin
      t_c  = '0;
      ld_c = 1'b1;
      d_c  = ld_val_c;
    end else if (tc) begin
`ifdef COUNTER_UPDOWN_MOD_SAT_EN
      t_c = '0;
`else
      // Force the wrap target; for power-of-two moduli this equals the
      // natural overflow result of the toggle chain.
      t_c        = '0;
      ld_c       = 1'b1;
      d_c        = (dir == DIR_UP) ? '0 : MAX_Q;
      wrap_nxt_c = 1'b1;
`endif
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    counter_bit_cell #(
      .RST (RST_V[i])
    ) u_cell (
      .clk (clk),
      .clr (clr),
      .t   (t_c[i]),
      .ld  (ld_c),
      .d   (d_c[i]),
      .q   (q[i])
    );
  end

  // Wrap pulse and sticky error flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      wrap <= wrap_nxt_c;
      if (load) err <= ~legal_ld_c;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench for counter_updown_mod (MODULUS=10, modulo build).
module tb_counter_updown_mod;

  localparam int unsigned W = 4;

  typedef struct {
    logic         load;
    logic         en;
    logic         up;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
    logic         err;
  } vec_t;

  logic         clk = 1'b0;
  logic         clr, en, up, load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         tc, wrap, err;

  logic         cclr, c_en;
  logic [W-1:0] lo_q, hi_q;
  logic         lo_tc, lo_wrap, lo_err, hi_tc, hi_wrap, hi_err;

  int n_total = 0;
  int n_pass  = 0;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  counter_updown_mod #(.MODULUS(10), .RESET_VAL(0)) dut (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d),
    .q(q), .tc(tc), .wrap(wrap), .err(err)
  );

  counter_updown_mod #(.MODULUS(10), .RESET_VAL(0)) u_lo (
    .clk(clk), .clr(cclr), .en(c_en), .up(1'b1), .load(1'b0), .d(4'd0),
    .q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .err(lo_err)
  );

  counter_updown_mod #(.MODULUS(10), .RESET_VAL(0)) u_hi (
    .clk(clk), .clr(cclr), .en(lo_tc), .up(1'b1), .load(1'b0), .d(4'd0),
    .q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .err(hi_err)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic ld, input logic e, input logic u,
                              input int dv, input int qv, input logic t,
                              input logic w, input logic er);
    vec_t v;
    v.load = ld; v.en = e; v.up = u; v.d = W'(dv);
    v.q = W'(qv); v.tc = t; v.wrap = w; v.err = er;
    return v;
  endfunction

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    load = v.load; en = v.en; up = v.up; d = v.d;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d q", idx),    int'(q),    int'(e.q));
    check($sformatf("vec%0d tc", idx),   int'(tc),   int'(e.tc));
    check($sformatf("vec%0d wrap", idx), int'(wrap), int'(e.wrap));
    check($sformatf("vec%0d err", idx),  int'(err),  int'(e.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lo_m, hi_m;

    // Up count 1..9,0,1,2
    for (int i = 1; i <= 9; i++) vecs.push_back(mk(0, 1, 1, 0, i, (i == 9), 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 2, 0, 0, 0));
    // Load 2, then down with wrap
    vecs.push_back(mk(1, 0, 1, 2, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 9, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8, 0, 0, 0));
    // Load priority and illegal load
    vecs.push_back(mk(1, 1, 1, 7, 7, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 12, 9, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 2, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 4, 4, 0, 0, 0));
    // Hold
    vecs.push_back(mk(0, 0, 1, 0, 4, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0));
    // Max d value, direction changes mid-count
    vecs.push_back(mk(1, 0, 1, 15, 9, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 8, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 9, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1));
    // Load boundaries: MODULUS-1 legal, MODULUS illegal, 0 clears err
    vecs.push_back(mk(1, 0, 0, 9, 9, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 10, 9, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
    // Set err and count down to 6 ahead of the async clear
    vecs.push_back(mk(1, 0, 1, 12, 9, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 8, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 7, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 6, 0, 0, 1));

    clr = 1'b1; cclr = 1'b1; c_en = 1'b0;
    en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    clr = 1'b0; cclr = 1'b0;
    #1;
    check("reset q", int'(q), 0);
    check("reset wrap", int'(wrap), 0);
    check("reset err", int'(err), 0);
    check("reset tc", int'(tc), 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Async clear between edges with q=6, err=1
    @(negedge clk);
    en = 1'b1; up = 1'b1; load = 1'b0;
    #1;
    clr = 1'b1;
    #1;
    check("async q", int'(q), 0);
    check("async err", int'(err), 0);
    check("async wrap", int'(wrap), 0);
    @(posedge clk); #1;
    check("clr hold1 q", int'(q), 0);
    @(posedge clk); #1;
    check("clr hold2 q", int'(q), 0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    check("release q", int'(q), 1);

    // Cascade: hi advances only when lo wraps 9->0
    lo_m = 0; hi_m = 0;
    @(negedge clk);
    c_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (lo_m == 9) begin
        lo_m = 0;
        hi_m = (hi_m == 9) ? 0 : hi_m + 1;
      end else begin
        lo_m = lo_m + 1;
      end
      @(posedge clk); #1;
      check($sformatf("casc%0d lo", i), int'(lo_q), lo_m);
      check($sformatf("casc%0d hi", i), int'(hi_q), hi_m);
    end
    check("casc final lo", int'(lo_q), 5);
    check("casc final hi", int'(hi_q), 2);
    @(negedge clk);
    c_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
